// File: rtl/aurora_pkg.sv
// Shared definitions for the Aurora link monitor: state encoding, default
// parameter values and a small saturating-increment helper.
package aurora_pkg;

  // FSM state encoding; the raw value is exported on state_o for debug.
  typedef logic [2:0] link_state_t;

  localparam link_state_t ST_IDLE     = 3'd0;
  localparam link_state_t ST_WAIT_UP  = 3'd1;
  localparam link_state_t ST_DEBOUNCE = 3'd2;
  localparam link_state_t ST_READY    = 3'd3;
  localparam link_state_t ST_RETRY    = 3'd4;
  localparam link_state_t ST_FAULT    = 3'd5;

  // Default timing and retry budget.
  localparam int DEF_TIMEOUT_CYCLES  = 20000;
  localparam int DEF_DEBOUNCE_CYCLES = 64;
  localparam int DEF_REINIT_CYCLES   = 16;
  localparam int DEF_MAX_RETRIES     = 7;
  localparam int DEF_SOFT_ERR_LIMIT  = 15;
  localparam int DEF_SOFT_ERR_WINDOW = 4096;

  // Increment a 4-bit counter, holding it at lim once reached.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser, asynchronous active-low reset to 0.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_sync;

  // Shift the asynchronous input through two flops to settle metastability.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= 2'b00;
    else          r_sync <= {r_sync[0], i_d};
  end

  assign o_q = r_sync[1];

endmodule

// File: rtl/aurora_link_monitor.sv
// Aurora channel bring-up supervisor. Watches channel_up/lane_up after the
// init sequencer fires start, debounces the link, declares link_ready, and
// requests reinit on timeout, link loss or hard error. Gives up (failed) after
// MAX_RETRIES consecutive failed attempts.
// Optional soft-error rate monitor: define AURORA_SOFT_ERR_MON_EN.
module aurora_link_monitor
  import aurora_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REINIT_CYCLES   = DEF_REINIT_CYCLES,
  parameter int MAX_RETRIES     = DEF_MAX_RETRIES,
  parameter int SOFT_ERR_LIMIT  = DEF_SOFT_ERR_LIMIT,
  parameter int SOFT_ERR_WINDOW = DEF_SOFT_ERR_WINDOW
) (
  input  logic       init_clk,
  input  logic       RST_N,
  input  logic       start,
  input  logic       channel_up,
  input  logic       lane_up,
  input  logic       hard_err,
  input  logic       soft_err,
  output logic       link_ready,
  output logic       reinit,
  output logic [3:0] retry_cnt,
  output logic       failed,
  output logic [2:0] state_o
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RI_W = $clog2(REINIT_CYCLES + 1);

  logic [1:0]     r_rst_sync;
  logic           w_rst_n;
  logic           w_chan_s, w_lane_s, w_hard_s, w_soft_s;
  logic           w_up_s;
  logic           r_start_q;
  logic           w_go;
  link_state_t    r_state, w_next_state, w_fail_state;
  logic [TO_W-1:0] r_to_cnt;
  logic [DB_W-1:0] r_db_cnt;
  logic [RI_W-1:0] r_ri_cnt;
  logic [3:0]     r_retry_cnt;
  logic           r_link_ready, r_reinit, r_failed;
  logic           w_to_expire, w_db_done, w_ri_done, w_last_try;
  logic           w_soft_trip;

  // Reset asserts asynchronously, releases on a clock edge.
  always_ff @(posedge init_clk or negedge RST_N) begin
    if (!RST_N) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  sync_2ff u_sync_chan (.i_clk(init_clk), .i_rst_n(w_rst_n), .i_d(channel_up), .o_q(w_chan_s));
  sync_2ff u_sync_lane (.i_clk(init_clk), .i_rst_n(w_rst_n), .i_d(lane_up),    .o_q(w_lane_s));
  sync_2ff u_sync_hard (.i_clk(init_clk), .i_rst_n(w_rst_n), .i_d(hard_err),   .o_q(w_hard_s));
  sync_2ff u_sync_soft (.i_clk(init_clk), .i_rst_n(w_rst_n), .i_d(soft_err),   .o_q(w_soft_s));

  assign w_up_s = w_chan_s & w_lane_s;

  // Delay start by one cycle so a multi-cycle pulse yields a single go.
  always_ff @(posedge init_clk or negedge w_rst_n) begin
    if (!w_rst_n) r_start_q <= 1'b0;
    else          r_start_q <= start;
  end

  assign w_go = start & ~r_start_q;

`ifdef AURORA_SOFT_ERR_MON_EN
  localparam int SW_W = $clog2(SOFT_ERR_WINDOW + 1);
  localparam int SC_W = $clog2(SOFT_ERR_LIMIT + 1);

  logic            r_soft_q;
  logic [SW_W-1:0] r_win_cnt;
  logic [SC_W-1:0] r_soft_cnt;
  logic            w_soft_rise, w_win_end;

  assign w_soft_rise = w_soft_s & ~r_soft_q;
  assign w_win_end   = (r_win_cnt == SW_W'(SOFT_ERR_WINDOW - 1));
  // The edge that brings the count to the limit trips the retry directly.
  assign w_soft_trip = (r_state == ST_READY) && w_soft_rise &&
                       (r_soft_cnt == SC_W'(SOFT_ERR_LIMIT - 1));

  // Count soft-error rising edges within a free-running window, READY only.
  always_ff @(posedge init_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_soft_q   <= 1'b0;
      r_win_cnt  <= '0;
      r_soft_cnt <= '0;
    end else begin
      r_soft_q  <= w_soft_s;
      r_win_cnt <= w_win_end ? '0 : r_win_cnt + 1'b1;
      if (w_win_end || (r_state != ST_READY)) r_soft_cnt <= '0;
      else if (w_soft_rise)                   r_soft_cnt <= r_soft_cnt + 1'b1;
    end
  end
`else
  logic w_unused_soft;
  assign w_soft_trip   = 1'b0;
  assign w_unused_soft = ^{w_soft_s, 1'(SOFT_ERR_LIMIT), 1'(SOFT_ERR_WINDOW)};
`endif

  assign w_to_expire  = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign w_db_done    = (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
  assign w_ri_done    = (r_ri_cnt == RI_W'(REINIT_CYCLES - 1));
  assign w_last_try   = (r_retry_cnt == 4'(MAX_RETRIES - 1));
  // A failed attempt goes straight to FAULT when it exhausts the budget.
  assign w_fail_state = w_last_try ? ST_FAULT : ST_RETRY;

  // Next-state selection.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:     if (w_go) w_next_state = ST_WAIT_UP;
      ST_WAIT_UP: begin
        if (w_up_s)           w_next_state = ST_DEBOUNCE;
        else if (w_to_expire) w_next_state = w_fail_state;
      end
      ST_DEBOUNCE: begin
        if (w_to_expire)      w_next_state = w_fail_state;
        else if (!w_up_s)     w_next_state = ST_WAIT_UP;
        else if (w_db_done)   w_next_state = ST_READY;
      end
      ST_READY:    if (!w_up_s || w_hard_s || w_soft_trip) w_next_state = w_fail_state;
      ST_RETRY:    if (w_ri_done) w_next_state = ST_IDLE;
      ST_FAULT:    w_next_state = ST_FAULT;
      default:     w_next_state = ST_IDLE;
    endcase
  end

  // State register and outputs decoded from the next state.
  always_ff @(posedge init_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state      <= ST_IDLE;
      r_link_ready <= 1'b0;
      r_reinit     <= 1'b0;
      r_failed     <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_link_ready <= (w_next_state == ST_READY);
      r_reinit     <= (w_next_state == ST_RETRY);
      r_failed     <= (w_next_state == ST_FAULT);
    end
  end

  // Timeout runs through WAIT_UP and DEBOUNCE; debounce and reinit counters
  // only run in their own state and sit at zero otherwise.
  always_ff @(posedge init_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_to_cnt <= '0;
      r_db_cnt <= '0;
      r_ri_cnt <= '0;
    end else begin
      if (r_state == ST_IDLE) r_to_cnt <= '0;
      else if ((r_state == ST_WAIT_UP) || (r_state == ST_DEBOUNCE)) r_to_cnt <= r_to_cnt + 1'b1;
      r_db_cnt <= (r_state == ST_DEBOUNCE) ? r_db_cnt + 1'b1 : '0;
      r_ri_cnt <= (r_state == ST_RETRY)    ? r_ri_cnt + 1'b1 : '0;
    end
  end

  // Consecutive-failure count: bump on each failed attempt, clear on READY.
  always_ff @(posedge init_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_retry_cnt <= 4'd0;
    end else if (w_next_state == ST_READY) begin
      r_retry_cnt <= 4'd0;
    end else if (((w_next_state == ST_RETRY) || (w_next_state == ST_FAULT)) &&
                 (w_next_state != r_state)) begin
      r_retry_cnt <= sat_inc4(r_retry_cnt, 4'(MAX_RETRIES));
    end
  end

  assign link_ready = r_link_ready;
  assign reinit     = r_reinit;
  assign retry_cnt  = r_retry_cnt;
  assign failed     = r_failed;
  assign state_o    = r_state;

endmodule
